at_cmd_sequencer: RTL and testbench
===================================

# at_cmd_sequencer

Parametrised AT-command sequencer driving an ESP8266 through the existing UART byte pipes. Walks a command table held in an external byte ROM, sends each command (optionally followed by CR LF), then waits for `OK\r\n`, `ERROR\r\n`, a timeout or a fixed delay. Retries failed commands up to a limit and reports done/error status. Replaces fixed per-instruction parameters with a table of any length and adds per-command modes, timeout and retry.

## Interface
- `ROM_AW`, default 10: command ROM address width.
- `TIMEOUT_CYC`, default 250_000_000: cycles allowed for an ack before a retry (5 s at 50 MHz).
- `DELAY_CYC`, default 50_000_000: wait used by no-ack commands.
- `MAX_RETRY`, default 3: retries per command before failure; the command is attempted MAX_RETRY+1 times in total.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; runs the table from address 0.
- `rom_addr` out ROM_AW: command ROM read address.
- `rom_data` in 8: ROM byte, valid one cycle after `rom_addr`.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_valid` out 1: byte offered.
- `tx_ready` in 1: `uart_tx` is idle and accepts the byte.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_valid` in 1: single-cycle strobe with `rx_data`.
- `busy` out 1: sequence running.
- `cfg_done` out 1: table completed, held high.
- `cfg_err` out 1: retries exhausted, held high.
- `cmd_idx` out 8: index of the current or failing command.

## Operation
- ROM layout is a list of entries. Each entry is a header byte, then ASCII bytes, then 0x00.
  - Header 0xFF marks the end of the table.
  - Header bit0 = `no_crlf`: do not append CR LF.
  - Header bit1 = `no_ack`: wait DELAY_CYC instead of matching a response.
- States: IDLE, HDR, FETCH, SEND, CR, LF, WAIT_ACK, DELAY, NEXT, DONE, FAIL.
- IDLE: on `start`, clear `cfg_done`/`cfg_err`, set `cmd_idx=0`, `base=0`, go to HDR. `start` in any other state is ignored.
- HDR: read the header at `base`.
  - 0xFF goes to DONE.
  - Otherwise latch the mode bits and go to FETCH at `base+1`.
- FETCH: read a byte.
  - 0x00 goes to CR, or to WAIT_ACK/DELAY when `no_crlf` is set.
  - Otherwise go to SEND.
- SEND, CR, LF: hold `tx_valid` with the byte until `tx_valid & tx_ready`. Then advance (SEND goes to FETCH at addr+1; CR sends 0x0D, LF sends 0x0A).
- After the last byte:
  - `no_ack` set: go to DELAY.
  - Otherwise go to WAIT_ACK. On entry, clear the match history and the timeout counter.
- WAIT_ACK: `rx_valid` bytes shift into a 7-byte history. The last 4 bytes equal to `OK\r\n` is a pass; the last 7 bytes equal to `ERROR\r\n` is a fail. Reaching TIMEOUT_CYC is also a fail. Bytes outside WAIT_ACK are discarded; the echoed command is harmless.
- On pass, or when DELAY expires: go to NEXT, which sets `base` to the address after the terminator, increments `cmd_idx`, clears the retry count, then goes to HDR.
- On fail:
  - Retry count < MAX_RETRY: increment it and go to HDR at the same `base`.
  - Otherwise go to FAIL.
- DONE raises `cfg_done`; FAIL raises `cfg_err` and freezes `cmd_idx`. Both return to IDLE, and the flags stay set until the next `start`.
- `busy` is high in every state except IDLE.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0`, `rom_addr=0`, `busy=0`, `cfg_done=0`, `cfg_err=0`, `cmd_idx=0`, state IDLE, counters and history 0.
- A reset mid-sequence aborts immediately. Any byte `uart_tx` has already taken completes on the line; nothing further is sent.
- ROM latency is 1 cycle, so each HDR/FETCH spends 2 cycles (address, then data).
- `tx_data` is stable while `tx_valid` is high; `tx_valid` drops the cycle after acceptance.
- A match is evaluated in the cycle after the `rx_valid` that completes it.
- If a match and the timeout occur in the same cycle, the match wins.
- The timeout counter saturates and is sized `$clog2(TIMEOUT_CYC+1)`.
- The DELAY counter is sized `$clog2(DELAY_CYC+1)`.
- `cmd_idx` wraps at 256.

## Structure
- Package `at_seq_pkg`:
  - state enum;
  - header bit positions `HDR_NO_CRLF=0`, `HDR_NO_ACK=1`, `HDR_END=8'hFF`;
  - byte constants `ACK_CR=8'h0D`, `ACK_LF=8'h0A`, and the `OK`/`ERROR` strings.
- Sub-module `at_resp_matcher`: holds the 7-byte history shift register with a synchronous clear. Outputs single-cycle `ok_hit` and `err_hit`.
- The ROM stays outside this block.

## Test plan
- Table {0x00,"AT",0x00,0xFF}; model answers `AT\r\nOK\r\n` -> TX bytes `41 54 0D 0A`, then `cfg_done=1`, `cmd_idx=1`, `busy=0`.
- Entry header 0x03 with "+++" -> exactly `2B 2B 2B` sent, no CR LF; with DELAY_CYC=100, the next header is read 100 (±2) cycles after the last byte is accepted.
- MAX_RETRY=2, model always replies `ERROR\r\n` -> command sent 3 times, then `cfg_err=1`, `cmd_idx=0`.
- TIMEOUT_CYC=1000, model silent -> resend after 1000 cycles; after retries are exhausted, `cfg_err=1`.
- `tx_ready` held low for 50 cycles during SEND -> `tx_data`/`tx_valid` held constant; no byte lost or duplicated.
- Assert `sys_rst` during WAIT_ACK, then send `start` -> all outputs at reset values; the sequence restarts at ROM address 0.

Source files
------------

// File: rtl/at_seq_pkg.sv
// Shared types and constants for the AT-command sequencer: FSM states, header
// bit positions and the response strings that the matcher looks for.
package at_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StFetch,
        StSend,
        StCr,
        StLf,
        StWaitAck,
        StDelay,
        StNext,
        StDone,
        StFail
    } seq_state_e;

    localparam int unsigned HDR_NO_CRLF = 0;
    localparam int unsigned HDR_NO_ACK  = 1;
    localparam logic [7:0]  HDR_END     = 8'hFF;

    localparam logic [7:0]  ACK_CR      = 8'h0D;
    localparam logic [7:0]  ACK_LF      = 8'h0A;
    localparam int unsigned HIST_BYTES  = 7;

    // "OK\r\n" and "ERROR\r\n", oldest byte in the most significant position
    localparam logic [31:0] ACK_OK    = {8'h4F, 8'h4B, ACK_CR, ACK_LF};
    localparam logic [55:0] ACK_ERROR = {8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, ACK_CR, ACK_LF};

endpackage

// File: rtl/at_resp_matcher.sv
// Seven-byte receive history; pulses ok_hit/err_hit for one cycle after the byte
// that completes "OK\r\n" or "ERROR\r\n".
module at_resp_matcher
    import at_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic       ok_hit_o,
    output logic       err_hit_o
);

    logic [8*HIST_BYTES-1:0] hist_q, hist_d;
    logic                    ok_q, ok_d;
    logic                    err_q, err_d;

    always_comb begin
        hist_d = hist_q;
        ok_d   = 1'b0;
        err_d  = 1'b0;
        if (clr_i) begin
            hist_d = '0;
        end else if (en_i) begin
            hist_d = {hist_q[8*HIST_BYTES-9:0], data_i};
            ok_d   = (hist_d[31:0] == ACK_OK);
            err_d  = (hist_d == ACK_ERROR);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            ok_q   <= ok_d;
            err_q  <= err_d;
        end
    end

    assign ok_hit_o  = ok_q;
    assign err_hit_o = err_q;

endmodule

// File: rtl/at_cmd_sequencer.sv
// Walks an AT-command table in an external byte ROM, sends each command over the
// UART byte pipe and waits for OK/ERROR, a timeout or a fixed delay, with retries.
module at_cmd_sequencer
    import at_seq_pkg::*;
#(
    parameter int unsigned ROM_AW      = 10,
    parameter int unsigned TIMEOUT_CYC = 250_000_000,
    parameter int unsigned DELAY_CYC   = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              busy_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    output logic [7:0]        cmd_idx_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DW = $clog2(DELAY_CYC + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] TmoMax   = TW'(TIMEOUT_CYC);
    localparam logic [DW-1:0] DlyLast  = DW'(DELAY_CYC - 1);
    localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);

    seq_state_e        state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_AW-1:0] base_q, base_d;
    logic [7:0]        cmd_idx_q, cmd_idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic              rd_phase_q, rd_phase_d;
    logic              no_crlf_q, no_crlf_d;
    logic              no_ack_q, no_ack_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic match_clr, rx_take, ok_hit, err_hit;
    logic cmd_sent, cmd_pass, cmd_fail;

    // Echoed command bytes and stray traffic outside WAIT_ACK never reach the history
    assign rx_take = rx_valid_i && (state_q == StWaitAck);

    at_resp_matcher u_matcher (
        .clk_i     (sys_clk_i),
        .rst_i     (sys_rst_i),
        .clr_i     (match_clr),
        .en_i      (rx_take),
        .data_i    (rx_data_i),
        .ok_hit_o  (ok_hit),
        .err_hit_o (err_hit)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        base_d     = base_q;
        cmd_idx_d  = cmd_idx_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        dly_d      = dly_q;
        rd_phase_d = rd_phase_q;
        no_crlf_d  = no_crlf_q;
        no_ack_d   = no_ack_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = done_q;
        err_d      = err_q;
        match_clr  = 1'b0;
        cmd_sent   = 1'b0;
        cmd_pass   = 1'b0;
        cmd_fail   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cmd_idx_d  = '0;
                    base_d     = '0;
                    rom_addr_d = '0;
                    retry_d    = '0;
                    rd_phase_d = 1'b0;
                    state_d    = StHdr;
                end
            end
            // Two cycles per ROM byte: address phase, then data phase
            StHdr: begin
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    if (rom_data_i == HDR_END) begin
                        state_d = StDone;
                    end else begin
                        no_crlf_d  = rom_data_i[HDR_NO_CRLF];
                        no_ack_d   = rom_data_i[HDR_NO_ACK];
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = StFetch;
                    end
                end
            end
            StFetch: begin
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    if (rom_data_i == 8'h00) begin
                        if (no_crlf_q) begin
                            cmd_sent = 1'b1;
                        end else begin
                            tx_data_d  = ACK_CR;
                            tx_valid_d = 1'b1;
                            state_d    = StCr;
                        end
                    end else begin
                        tx_data_d  = rom_data_i;
                        tx_valid_d = 1'b1;
                        state_d    = StSend;
                    end
                end
            end
            StSend: begin
                if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = StFetch;
                end
            end
            StCr: begin
                if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = ACK_LF;
                    state_d    = StLf;
                end
            end
            StLf: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    cmd_sent   = 1'b1;
                end
            end
            StWaitAck: begin
                if (ok_hit) begin
                    cmd_pass = 1'b1;
                end else if (err_hit || (tmo_q == TmoMax)) begin
                    cmd_fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDelay: begin
                if (dly_q == DlyLast) begin
                    cmd_pass = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StNext: begin
                base_d     = rom_addr_q;
                cmd_idx_d  = cmd_idx_q + 8'd1;
                retry_d    = '0;
                rd_phase_d = 1'b0;
                state_d    = StHdr;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StFail: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (cmd_sent) begin
            if (no_ack_q) begin
                dly_d   = '0;
                state_d = StDelay;
            end else begin
                tmo_d     = '0;
                match_clr = 1'b1;
                state_d   = StWaitAck;
            end
        end

        // rom_addr still points at the terminator; step past it for the next header
        if (cmd_pass) begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = StNext;
        end

        if (cmd_fail) begin
            if (retry_q < RetryMax) begin
                retry_d    = retry_q + 1'b1;
                rom_addr_d = base_q;
                rd_phase_d = 1'b0;
                state_d    = StHdr;
            end else begin
                state_d = StFail;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            base_q     <= '0;
            cmd_idx_q  <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            dly_q      <= '0;
            rd_phase_q <= 1'b0;
            no_crlf_q  <= 1'b0;
            no_ack_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            base_q     <= base_d;
            cmd_idx_q  <= cmd_idx_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            dly_q      <= dly_d;
            rd_phase_q <= rd_phase_d;
            no_crlf_q  <= no_crlf_d;
            no_ack_q   <= no_ack_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = (state_q != StIdle);
    assign cfg_done_o = done_q;
    assign cfg_err_o  = err_q;
    assign cmd_idx_o  = cmd_idx_q;

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// Directed bench for at_cmd_sequencer: ROM model, UART tx sink and a scripted
// ESP8266 responder, with hand-computed expected bytes, flags and timings.
module tb_at_cmd_sequencer;

    localparam int unsigned AW    = 8;
    localparam int unsigned TMO   = 1000;
    localparam int unsigned DLY   = 100;
    localparam int unsigned RETRY = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          busy, cfg_done, cfg_err;
    logic [7:0]    cmd_idx;

    logic [7:0] rom [256];
    logic [7:0] img [$];
    logic [7:0] tx_log [$];
    time        acc_log [$];
    int         lf_cnt = 0;
    int         lf_served = 0;
    int         resp_mode = 0;
    int         n_vec = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    at_cmd_sequencer #(
        .ROM_AW      (AW),
        .TIMEOUT_CYC (TMO),
        .DELAY_CYC   (DLY),
        .MAX_RETRY   (RETRY)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .start_i    (start),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .busy_o     (busy),
        .cfg_done_o (cfg_done),
        .cfg_err_o  (cfg_err),
        .cmd_idx_o  (cmd_idx)
    );

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    // A byte seen offered and ready at the negedge is taken on the next posedge
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            tx_log.push_back(tx_data);
            acc_log.push_back($time);
            if (tx_data == 8'h0A) lf_cnt++;
        end
    end

    task automatic send_seq(input int mode);
        logic [7:0] s [$];
        if (mode == 1) s = '{8'h41, 8'h54, 8'h0D, 8'h0A, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
        else           s = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};
        foreach (s[i]) begin
            @(posedge clk); #1;
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    always begin
        @(negedge clk);
        if (lf_cnt != lf_served) begin
            lf_served = lf_cnt;
            if (resp_mode != 0) begin
                repeat (3) @(posedge clk);
                send_seq(resp_mode);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_tx_valid"}, 64'(tx_valid), 64'(0));
        check({pfx, "_tx_data"},  64'(tx_data),  64'(0));
        check({pfx, "_rom_addr"}, 64'(rom_addr), 64'(0));
        check({pfx, "_busy"},     64'(busy),     64'(0));
        check({pfx, "_done"},     64'(cfg_done), 64'(0));
        check({pfx, "_err"},      64'(cfg_err),  64'(0));
        check({pfx, "_cmd_idx"},  64'(cmd_idx),  64'(0));
    endtask

    task automatic load_img();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        foreach (img[i]) rom[i] = img[i];
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    function automatic logic [63:0] pack(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if (base + i < tx_log.size()) v = {v[55:0], tx_log[base+i]};
            else                          v = {v[55:0], 8'hXX};
        end
        return v;
    endfunction

    initial begin
        int  b;
        int  n;
        int  delta;
        time t_k;
        logic [7:0] d0;
        bit  stable;

        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(posedge clk); #1 rst = 1'b0;

        // Plain "AT" with CR LF, answered with echo + OK
        img = '{8'h00, 8'h41, 8'h54, 8'h00, 8'hFF};
        load_img();
        resp_mode = 1;
        b = tx_log.size();
        pulse_start();
        wait_done("t1_finish", 2000);
        check("t1_count", 64'(tx_log.size() - b), 64'(4));
        check("t1_bytes", pack(b, 4), 64'h41540D0A);
        check("t1_done", 64'(cfg_done), 64'(1));
        check("t1_err", 64'(cfg_err), 64'(0));
        check("t1_cmd_idx", 64'(cmd_idx), 64'(1));

        // "+++" with no_crlf and no_ack, then delay before the next header at 5
        img = '{8'h03, 8'h2B, 8'h2B, 8'h2B, 8'h00, 8'hFF};
        load_img();
        resp_mode = 0;
        b = tx_log.size();
        pulse_start();
        n = 0;
        while (rom_addr != 8'd5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        t_k = $time;
        check("t2_hdr_reached", 64'(rom_addr), 64'(5));
        check("t2_count", 64'(tx_log.size() - b), 64'(3));
        check("t2_bytes", pack(b, 3), 64'h2B2B2B);
        delta = (acc_log.size() > 0) ? int'((t_k - acc_log[acc_log.size()-1]) / 10) - 1 : 0;
        check("t2_delay_window", 64'(delta >= 98 && delta <= 102), 64'(1));
        wait_done("t2_finish", 200);
        check("t2_done", 64'(cfg_done), 64'(1));
        check("t2_cmd_idx", 64'(cmd_idx), 64'(1));

        // Always ERROR: three attempts, then failure on command 0
        img = '{8'h00, 8'h41, 8'h54, 8'h00, 8'hFF};
        load_img();
        resp_mode = 2;
        b = tx_log.size();
        pulse_start();
        wait_done("t3_finish", 3000);
        check("t3_count", 64'(tx_log.size() - b), 64'(12));
        check("t3_last", pack(b + 8, 4), 64'h41540D0A);
        check("t3_err", 64'(cfg_err), 64'(1));
        check("t3_done", 64'(cfg_done), 64'(0));
        check("t3_cmd_idx", 64'(cmd_idx), 64'(0));

        // Silent module: resend after the timeout, then failure
        resp_mode = 0;
        b = tx_log.size();
        pulse_start();
        wait_done("t4_finish", 5000);
        check("t4_count", 64'(tx_log.size() - b), 64'(12));
        delta = (tx_log.size() - b >= 5) ? int'((acc_log[b+4] - acc_log[b+3]) / 10) : 0;
        check("t4_resend_gap", 64'(delta >= 1000 && delta <= 1010), 64'(1));
        check("t4_err", 64'(cfg_err), 64'(1));
        check("t4_cmd_idx", 64'(cmd_idx), 64'(0));

        // Back-pressure: tx_ready low for 50 cycles while the first byte is offered
        resp_mode = 1;
        tx_ready  = 1'b0;
        b = tx_log.size();
        pulse_start();
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        d0 = tx_data;
        stable = tx_valid;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== d0) stable = 1'b0;
        end
        check("t5_hold_stable", 64'(stable), 64'(1));
        check("t5_hold_data", 64'(d0), 64'h41);
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_done("t5_finish", 2000);
        check("t5_count", 64'(tx_log.size() - b), 64'(4));
        check("t5_bytes", pack(b, 4), 64'h41540D0A);
        check("t5_done", 64'(cfg_done), 64'(1));

        // Reset while waiting for the ack, then a clean rerun from address 0
        resp_mode = 0;
        b = tx_log.size();
        pulse_start();
        n = 0;
        while (tx_log.size() < b + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("t6_busy_before", 64'(busy), 64'(1));
        @(posedge clk); #1 rst = 1'b1;
        #1 check_reset("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        resp_mode = 1;
        b = tx_log.size();
        pulse_start();
        wait_done("t6_finish", 2000);
        check("t6_count", 64'(tx_log.size() - b), 64'(4));
        check("t6_bytes", pack(b, 4), 64'h41540D0A);
        check("t6_done", 64'(cfg_done), 64'(1));
        check("t6_cmd_idx", 64'(cmd_idx), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
